// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the core memory port: FSM states, address map
// constants and the target index constants used by the request demux.
package riscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bus_state_e;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  localparam int unsigned TGT_RAM  = 0;
  localparam int unsigned TGT_MMIO = 1;

endpackage

// File: rtl/bus_demux_2_mux.sv
// Plain 2:1 multiplexer, shared by the bus blocks for per-target data selection.
module bus_demux_2_mux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  input  logic             Select,
  output logic [WIDTH-1:0] Out
);

  assign Out = Select ? In1 : In0;

endmodule

// File: rtl/bus_demux_2.sv
// Steers the core's single memory-request port to the data RAM or the MMIO
// block, returns the selected response, and converts a hung target into an error.
module bus_demux_2 #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] MMIO_BASE = AW'(riscv_bus_pkg::MMIO_BASE),
  parameter int unsigned   TIMEOUT   = 255,
  parameter logic [DW-1:0] ERR_DATA  = DW'(riscv_bus_pkg::ERR_DATA)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [AW-1:0]     Req_Addr,
  input  logic              Req_WE,
  input  logic [DW/8-1:0]   Req_BE,
  input  logic [DW-1:0]     Req_WData,
  output logic              Rsp_Valid,
  output logic [DW-1:0]     Rsp_RData,
  output logic              Rsp_Err,
  output logic [1:0]        Tgt_Valid,
  input  logic [1:0]        Tgt_Ready,
  output logic [AW-1:0]     Tgt_Addr,
  output logic              Tgt_WE,
  output logic [DW/8-1:0]   Tgt_BE,
  output logic [DW-1:0]     Tgt_WData,
  input  logic [1:0]        Tgt_RspValid,
  input  logic [2*DW-1:0]   Tgt_RData
);

  import riscv_bus_pkg::*;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  bus_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW/8-1:0]     be_q, be_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic                sel_q, sel_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DW-1:0]       sel_rdata;
  logic                sel_ready;
  logic                sel_rsp;
  logic                timed_out;

  bus_demux_2_mux #(
    .WIDTH (DW)
  ) u_rdata_mux (
    .In0    (Tgt_RData[DW-1:0]),
    .In1    (Tgt_RData[2*DW-1:DW]),
    .Select (sel_q),
    .Out    (sel_rdata)
  );

  // Only the selected target's handshake and response strobes are ever looked at.
  assign sel_ready = Tgt_Ready[sel_q];
  assign sel_rsp   = Tgt_RspValid[sel_q];
  assign timed_out = (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          addr_d  = Req_Addr;
          we_d    = Req_WE;
          be_d    = Req_BE;
          wdata_d = Req_WData;
          sel_d   = (Req_Addr >= MMIO_BASE);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      // A response arriving on the timeout cycle still wins over the watchdog.
      ISSUE: begin
        if (sel_ready && sel_rsp) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (sel_ready) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = WAIT;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (sel_rsp) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is held low while reset is asserted even though the state is IDLE.
  always_comb begin
    Tgt_Valid = 2'b00;
    if (state_q == ISSUE) begin
      Tgt_Valid[TGT_MMIO] = sel_q;
      Tgt_Valid[TGT_RAM]  = ~sel_q;
    end
  end

  assign Req_Ready = Rst_n && (state_q == IDLE);
  assign Rsp_Valid = (state_q == RESP);
  assign Rsp_Err   = (state_q == RESP) && err_q;
  assign Rsp_RData = rdata_q;

  assign Tgt_Addr  = addr_q;
  assign Tgt_WE    = we_q;
  assign Tgt_BE    = be_q;
  assign Tgt_WData = wdata_q;

endmodule
